fifo_wr_arb: RTL and testbench

- Round-robin arbiter that shares one FIFO write port among N_SRC byte generators.
- Each generator presents a request and a data word. The arbiter grants one source at a time for a bounded burst and drives the FIFO wrreq/data pair.
- It honours the FIFO full flag and a global enable.
- It sits between the gen instances and the FIFO, replacing direct gen-to-FIFO wiring.

---
 rtl/fifo_wr_arb.sv | 117 +++++++++++
 tb/tb_fifo_wr_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among N_SRC sources.
// A grant lasts up to BURST_LEN accepted words; full stalls without ending the burst.
module fifo_wr_arb #(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [N_SRC-1:0]          req,
    input  logic [N_SRC*DATA_W-1:0]   wdata,
    input  logic                      full,
    output logic [N_SRC-1:0]          gnt,
    output logic                      wrreq,
    output logic [DATA_W-1:0]         data,
    output logic [(N_SRC>1 ? $clog2(N_SRC) : 1)-1:0] owner,
    output logic                      busy
);

    localparam int OW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [OW-1:0]   owner_r, owner_nxt_s;
    logic [OW-1:0]   last_r, last_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic [OW-1:0]   pick_s;
    logic            found_s;
    logic            hit_s;
    logic            accept_s;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        pick_s  = last_r;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int d = 1; d <= N_SRC; d++) begin
            hit_s   = req[(int'(last_r) + d) % N_SRC];
            pick_s  = (!found_s && hit_s) ? OW'((int'(last_r) + d) % N_SRC) : pick_s;
            found_s = found_s | hit_s;
        end
    end

    assign accept_s = (state_r == BURST) && en && req[owner_r] && !full;

    // Zero-latency write path: the owner's word goes straight to the FIFO when accepted.
    always_comb begin
        gnt   = {N_SRC{1'b0}};
        wrreq = accept_s;
        data  = accept_s ? wdata[int'(owner_r)*DATA_W +: DATA_W] : {DATA_W{1'b0}};
        busy  = (state_r == BURST);
        owner = owner_r;
        for (int k = 0; k < N_SRC; k++) begin
            gnt[k] = accept_s && (owner_r == OW'(k));
        end
    end

    // Next-state logic: en low or owner release always ends the burst; full only stalls.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (en && (req != {N_SRC{1'b0}})) begin
                    state_nxt_s = BURST;
                    owner_nxt_s = pick_s;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                if (!en || !req[owner_r]) begin
                    state_nxt_s = IDLE;
                    last_nxt_s  = owner_r;
                    cnt_nxt_s   = {CW{1'b0}};
                end else if (accept_s && (cnt_r == CW'(BURST_LEN - 1))) begin
                    state_nxt_s = IDLE;
                    last_nxt_s  = owner_r;
                    cnt_nxt_s   = {CW{1'b0}};
                end else if (accept_s) begin
                    cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt_s   = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State register; reset leaves source 0 with first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            owner_r <= {OW{1'b0}};
            last_r  <= OW'(N_SRC - 1);
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            last_r  <= last_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the arbitration rules.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int OW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            full;
    logic [N-1:0]    req;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic            wrreq;
    logic [DW-1:0]   data;
    logic [OW-1:0]   owner;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit m_busy;
    int m_owner;
    int m_last;
    int m_cnt;

    logic [N-1:0]  e_gnt;
    logic          e_wr;
    logic [DW-1:0] e_data;

    fifo_wr_arb #(.N_SRC(N), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .wdata(wdata),
        .full(full), .gnt(gnt), .wrreq(wrreq), .data(data),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int d = 1; d <= N; d++) begin
            if (r[(last + d) % N]) return (last + d) % N;
        end
        return last;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_cnt   = 0;
    endtask

    // Drive one cycle of inputs and compute the expected combinational outputs.
    task automatic apply(input logic [N-1:0] r, input logic e, input logic f);
        bit acc;
        req   = r;
        en    = e;
        full  = f;
        wdata = $urandom;
        #3;
        acc    = m_busy && e && r[m_owner] && !f;
        e_wr   = acc;
        e_gnt  = acc ? (N'(1) << m_owner) : '0;
        e_data = acc ? wdata[m_owner*DW +: DW] : '0;
    endtask

    // Advance to the next clock edge and update the model with the applied inputs.
    task automatic tick();
        @(posedge clk);
        if (!m_busy) begin
            if (en && req != '0) begin
                m_owner = rr_pick(m_last, req);
                m_cnt   = 0;
                m_busy  = 1'b1;
            end
        end else if (!en || !req[m_owner]) begin
            m_busy = 1'b0; m_last = m_owner; m_cnt = 0;
        end else if (!full) begin
            m_cnt++;
            if (m_cnt == BL) begin
                m_busy = 1'b0; m_last = m_owner; m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; req = '0; en = 1'b0; full = 1'b0; wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        for (int k = 0; k < 20; k++) begin
            apply('0, 1'b1, 1'b0);
            n_checks++;
            if ({gnt, wrreq, data, busy, owner} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got gnt=%b wr=%b data=%h busy=%b owner=%0d want all 0",
                         k, gnt, wrreq, data, busy, owner);
            end
            tick();
        end
    endtask

    task automatic test_single();
        logic expw;
        reset_dut();
        for (int k = 0; k < 20; k++) begin
            apply(4'b0001, 1'b1, 1'b0);
            expw = (k % 5) != 0;
            n_checks++;
            if (wrreq !== expw || gnt !== (expw ? 4'b0001 : 4'b0000) ||
                data !== (expw ? wdata[DW-1:0] : 8'h00)) begin
                n_fail++;
                $display("FAIL single_src cyc=%0d got wr=%b gnt=%b data=%h want wr=%b data=%h",
                         k, wrreq, gnt, data, expw, expw ? wdata[DW-1:0] : 8'h00);
            end
            tick();
        end
    endtask

    task automatic test_rotation();
        int owners[$];
        reset_dut();
        for (int k = 0; k < 20; k++) begin
            apply(4'b1010, 1'b1, 1'b0);
            if (wrreq === 1'b1) owners.push_back(int'(owner));
            tick();
        end
        n_checks++;
        if (owners.size() != 16) begin
            n_fail++;
            $display("FAIL rot_1010_count got %0d writes want 16", owners.size());
        end
        for (int i = 0; i < owners.size(); i++) begin
            n_checks++;
            if (owners[i] != (((i / 4) % 2 == 0) ? 1 : 3)) begin
                n_fail++;
                $display("FAIL rot_1010 write=%0d got owner=%0d want %0d",
                         i, owners[i], ((i / 4) % 2 == 0) ? 1 : 3);
            end
        end
        owners.delete();
        reset_dut();
        for (int k = 0; k < 25; k++) begin
            apply(4'b1111, 1'b1, 1'b0);
            if (wrreq === 1'b1) owners.push_back(int'(owner));
            tick();
        end
        n_checks++;
        if (owners.size() != 20) begin
            n_fail++;
            $display("FAIL rot_all_count got %0d writes want 20", owners.size());
        end
        for (int i = 0; i < owners.size(); i++) begin
            n_checks++;
            if (owners[i] != (i / 4) % 4) begin
                n_fail++;
                $display("FAIL rot_all write=%0d got owner=%0d want %0d", i, owners[i], (i / 4) % 4);
            end
        end
    endtask

    task automatic test_full_stall();
        int writes;
        bit done;
        reset_dut();
        apply(4'b0001, 1'b1, 1'b0); tick();
        apply(4'b0001, 1'b1, 1'b0); tick();
        apply(4'b0001, 1'b1, 1'b0); tick();
        for (int k = 0; k < 3; k++) begin
            apply(4'b0001, 1'b1, 1'b1);
            n_checks++;
            if (wrreq !== 1'b0 || gnt !== '0 || busy !== 1'b1 || owner !== 2'd0) begin
                n_fail++;
                $display("FAIL full_stall cyc=%0d got wr=%b gnt=%b busy=%b owner=%0d want 0 0 1 0",
                         k, wrreq, gnt, busy, owner);
            end
            tick();
        end
        writes = 0;
        done   = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            apply(4'b0001, 1'b1, 1'b0);
            if (busy !== 1'b1) done = 1'b1;
            else if (wrreq === 1'b1) writes++;
            tick();
        end
        n_checks++;
        if (!done || writes != 2) begin
            n_fail++;
            $display("FAIL full_resume got %0d writes (ended=%0d) want 2", writes, done);
        end
    endtask

    task automatic test_enable_release();
        reset_dut();
        apply(4'b0001, 1'b1, 1'b0); tick();
        apply(4'b0001, 1'b1, 1'b0); tick();
        apply(4'b0001, 1'b0, 1'b0);
        n_checks++;
        if (wrreq !== 1'b0 || gnt !== '0) begin
            n_fail++;
            $display("FAIL en_low got wr=%b gnt=%b want 0 0", wrreq, gnt);
        end
        tick();
        apply(4'b0001, 1'b1, 1'b0);
        n_checks++;
        if (busy !== 1'b0 || wrreq !== 1'b0) begin
            n_fail++;
            $display("FAIL en_low_idle got busy=%b wr=%b want 0 0", busy, wrreq);
        end
        tick();
        reset_dut();
        apply(4'b0011, 1'b1, 1'b0); tick();
        apply(4'b0011, 1'b1, 1'b0); tick();
        apply(4'b0010, 1'b1, 1'b0);
        n_checks++;
        if (wrreq !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL release got wr=%b busy=%b want 0 1", wrreq, busy);
        end
        tick();
        apply(4'b0010, 1'b1, 1'b0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle got busy=%b want 0", busy);
        end
        tick();
        apply(4'b0010, 1'b1, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || owner !== 2'd1 || gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL release_next got busy=%b owner=%0d gnt=%b want 1 1 0010", busy, owner, gnt);
        end
        tick();
    endtask

    task automatic test_async_reset();
        reset_dut();
        apply(4'b0101, 1'b1, 1'b0); tick();
        apply(4'b0101, 1'b1, 1'b0); tick();
        apply(4'b0101, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, wrreq, data, busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got gnt=%b wr=%b data=%h busy=%b want all 0", gnt, wrreq, data, busy);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(4'b0101, 1'b1, 1'b0); tick();
        apply(4'b0101, 1'b1, 1'b0);
        n_checks++;
        if (owner !== 2'd0 || gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL post_reset_prio got owner=%0d gnt=%b want 0 0001", owner, gnt);
        end
        tick();
    endtask

    task automatic test_random();
        reset_dut();
        for (int k = 0; k < 600; k++) begin
            apply(N'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0);
            n_checks++;
            if ({gnt, wrreq, data, busy, owner} !== {e_gnt, e_wr, e_data, m_busy, OW'(m_owner)}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got gnt=%b wr=%b data=%h busy=%b owner=%0d want gnt=%b wr=%b data=%h busy=%b owner=%0d",
                         k, gnt, wrreq, data, busy, owner, e_gnt, e_wr, e_data, m_busy, m_owner);
            end
            n_checks++;
            if (wrreq === 1'b1 && full === 1'b1) begin
                n_fail++;
                $display("FAIL wr_while_full cyc=%0d got wr=1 full=1 want wr=0", k);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_full_stall();
        test_enable_release();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
